// File: rtl/seq_bit_gen_if.sv
// seq_bit_gen_if: valid/ready word handshake into the serial generator.
// Ports: in_valid, in_data (source -> gen); in_ready (gen -> source).
interface seq_bit_gen_if #(
  parameter int WIDTH = 8
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );
endinterface

// File: rtl/seq_bit_gen.sv
// seq_bit_gen: shifts handshaken words out one bit per clock, with a
// cycle-aligned "11" hit reference for scoring a sequence detector.
// Ports: clk; rst (sync, high); in_if (slave: in_valid/in_ready/in_data);
// dout, dout_valid, frame_done, exp_hit (registered); busy.
module seq_bit_gen #(
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 0,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  seq_bit_gen_if.slave in_if,
  output logic         dout,
  output logic         dout_valid,
  output logic         frame_done,
  output logic         exp_hit,
  output logic         busy
);

  if (WIDTH < 2) begin : g_bad_width
    $error("seq_bit_gen: WIDTH must be >= 2");
  end
  if (GAP_CYCLES < 0) begin : g_bad_gap
    $error("seq_bit_gen: GAP_CYCLES must be >= 0");
  end

  localparam int CW = $clog2(WIDTH);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [CW-1:0]    bit_cnt, bit_cnt_n;
  logic [GW-1:0]    gap_cnt, gap_cnt_n;
  logic             prev_bit, prev_n;
  logic             dout_n, dv_n, fd_n, hit_n;
  logic             cur_bit;
  logic [WIDTH-1:0] shifted;

  assign cur_bit = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
  assign shifted = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0}
                             : {1'b0, shreg[WIDTH-1:1]};

  assign in_if.in_ready = (state == IDLE) && !rst;
  assign busy           = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      prev_bit   <= 1'b0;
      dout       <= 1'b0;
      dout_valid <= 1'b0;
      frame_done <= 1'b0;
      exp_hit    <= 1'b0;
    end else begin
      state      <= state_n;
      shreg      <= shreg_n;
      bit_cnt    <= bit_cnt_n;
      gap_cnt    <= gap_cnt_n;
      prev_bit   <= prev_n;
      dout       <= dout_n;
      dout_valid <= dv_n;
      frame_done <= fd_n;
      exp_hit    <= hit_n;
    end
  end

  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    bit_cnt_n = bit_cnt;
    gap_cnt_n = gap_cnt;
    prev_n    = prev_bit;
    dout_n    = 1'b0;
    dv_n      = 1'b0;
    fd_n      = 1'b0;
    hit_n     = 1'b0;
    unique case (state)
      IDLE: begin
        // rst already forces in_ready low and wins in the register
        if (in_if.in_valid) begin
          shreg_n   = in_if.in_data;
          bit_cnt_n = '0;
          prev_n    = 1'b0;
          state_n   = SHIFT;
        end
      end
      SHIFT: begin
        dout_n    = cur_bit;
        dv_n      = 1'b1;
        hit_n     = cur_bit & prev_bit;
        prev_n    = cur_bit;
        shreg_n   = shifted;
        bit_cnt_n = bit_cnt + 1'b1;
        if (bit_cnt == CW'(WIDTH - 1)) begin
          fd_n      = 1'b1;
          bit_cnt_n = '0;
          gap_cnt_n = '0;
          state_n   = (GAP_CYCLES > 0) ? GAP : IDLE;
        end
      end
      GAP: begin
        gap_cnt_n = gap_cnt + 1'b1;
        if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
          gap_cnt_n = '0;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_seq_bit_gen.sv
// tb_seq_bit_gen: three generator configs on one stimulus stream,
// scored against a frame-level reference model and fixed vectors.
module tb_seq_bit_gen;
  localparam int W = 8;

  typedef struct packed {
    logic       r;
    logic       v;
    logic [7:0] d;
    logic [5:0] e;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vld = 1'b0;
  logic [7:0] dat = '0;
  logic [2:0] dout, dv, fd, hit, busy, rdy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_bit_gen_if #(.WIDTH(W)) b0 ();
  seq_bit_gen_if #(.WIDTH(W)) b1 ();
  seq_bit_gen_if #(.WIDTH(W)) b2 ();

  assign b0.in_valid = vld;
  assign b0.in_data  = dat;
  assign b1.in_valid = vld;
  assign b1.in_data  = dat;
  assign b2.in_valid = vld;
  assign b2.in_data  = dat;
  assign rdy = {b2.in_ready, b1.in_ready, b0.in_ready};

  seq_bit_gen #(.WIDTH(W), .GAP_CYCLES(0), .MSB_FIRST(1'b1)) u0 (
    .clk(clk), .rst(rst), .in_if(b0),
    .dout(dout[0]), .dout_valid(dv[0]), .frame_done(fd[0]),
    .exp_hit(hit[0]), .busy(busy[0])
  );

  seq_bit_gen #(.WIDTH(W), .GAP_CYCLES(3), .MSB_FIRST(1'b1)) u1 (
    .clk(clk), .rst(rst), .in_if(b1),
    .dout(dout[1]), .dout_valid(dv[1]), .frame_done(fd[1]),
    .exp_hit(hit[1]), .busy(busy[1])
  );

  seq_bit_gen #(.WIDTH(W), .GAP_CYCLES(0), .MSB_FIRST(1'b0)) u2 (
    .clk(clk), .rst(rst), .in_if(b2),
    .dout(dout[2]), .dout_valid(dv[2]), .frame_done(fd[2]),
    .exp_hit(hit[2]), .busy(busy[2])
  );

  int   gap_p [3] = '{0, 3, 0};
  bit   msb_p [3] = '{1'b1, 1'b1, 1'b0};
  bit   m_act [3] = '{1'b0, 1'b0, 1'b0};
  int   m_t   [3] = '{0, 0, 0};
  logic [7:0] m_w   [3] = '{8'h0, 8'h0, 8'h0};
  logic [3:0] m_reg [3] = '{4'h0, 4'h0, 4'h0};

  int   hit_cnt [3];
  int   fd_cnt  [3];
  logic [7:0] seq [3];

  function automatic logic bitk(int i, int k);
    int sh;
    sh = msb_p[i] ? (W - k) : (k - 1);
    return logic'((m_w[i] >> sh) & 8'h01);
  endfunction

  // Frame timeline: edge t after the handshake carries bit t for
  // t = 1..W, then idle gap edges; the frame ends at t = W + gap.
  task automatic model(int i);
    int   k;
    logic b, pb;
    if (rst) begin
      m_act[i] = 1'b0;
      m_reg[i] = '0;
    end else if (!m_act[i]) begin
      m_reg[i] = '0;
      if (vld) begin
        m_act[i] = 1'b1;
        m_t[i]   = 0;
        m_w[i]   = dat;
      end
    end else begin
      m_t[i] = m_t[i] + 1;
      k = m_t[i];
      if (k <= W) begin
        b  = bitk(i, k);
        pb = (k > 1) ? bitk(i, k - 1) : 1'b0;
        m_reg[i] = {b, 1'b1, logic'(k == W), b & pb};
      end else begin
        m_reg[i] = '0;
      end
      if (m_t[i] == W + gap_p[i]) m_act[i] = 1'b0;
    end
  endtask

  task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", nm, a, e, $time);
    end
  endtask

  task automatic clr();
    for (int i = 0; i < 3; i++) begin
      hit_cnt[i] = 0;
      fd_cnt[i]  = 0;
      seq[i]     = '0;
    end
  endtask

  task automatic step();
    logic [5:0] e, a;
    @(posedge clk);
    for (int i = 0; i < 3; i++) model(i);
    #1;
    for (int i = 0; i < 3; i++) begin
      e = {~m_act[i] & ~rst, m_act[i], m_reg[i]};
      a = {rdy[i], busy[i], dout[i], dv[i], fd[i], hit[i]};
      chk($sformatf("model%0d", i), 32'(a), 32'(e));
      hit_cnt[i] += int'(hit[i]);
      fd_cnt[i]  += int'(fd[i]);
      seq[i] = {seq[i][6:0], dout[i]};
    end
  endtask

  task automatic idle(int n);
    vld = 1'b0;
    repeat (n) step();
  endtask

  vec_t tbl [14];
  int   dvlo;

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 8'hFF, 6'b000000};
    tbl[1]  = '{1'b1, 1'b1, 8'hFF, 6'b000000};
    tbl[2]  = '{1'b1, 1'b1, 8'hFF, 6'b000000};
    tbl[3]  = '{1'b0, 1'b0, 8'h00, 6'b100000};
    tbl[4]  = '{1'b0, 1'b1, 8'hB6, 6'b010000};
    tbl[5]  = '{1'b0, 1'b0, 8'h00, 6'b011100};
    tbl[6]  = '{1'b0, 1'b0, 8'h00, 6'b010100};
    tbl[7]  = '{1'b0, 1'b0, 8'h00, 6'b011100};
    tbl[8]  = '{1'b0, 1'b0, 8'h00, 6'b011101};
    tbl[9]  = '{1'b0, 1'b0, 8'h00, 6'b010100};
    tbl[10] = '{1'b0, 1'b0, 8'h00, 6'b011100};
    tbl[11] = '{1'b0, 1'b0, 8'h00, 6'b011101};
    tbl[12] = '{1'b0, 1'b0, 8'h00, 6'b100110};
    tbl[13] = '{1'b0, 1'b0, 8'h00, 6'b100000};

    clr();
    for (int j = 0; j < 14; j++) begin
      rst = tbl[j].r;
      vld = tbl[j].v;
      dat = tbl[j].d;
      step();
      chk($sformatf("vec%0d", j),
          32'({rdy[0], busy[0], dout[0], dv[0], fd[0], hit[0]}),
          32'(tbl[j].e));
    end
    idle(15);

    // back-to-back FF then 00 with in_valid held
    clr();
    vld = 1'b1;
    dat = 8'hFF;
    step();
    dat = 8'h00;
    repeat (9) step();
    idle(15);
    chk("ff00_hits0", 32'(hit_cnt[0]), 32'd7);
    chk("ff00_fd0", 32'(fd_cnt[0]), 32'd2);
    chk("ff00_fd1", 32'(fd_cnt[1]), 32'd1);

    // gap config: next frame starts 12 edges after the handshake
    clr();
    vld  = 1'b1;
    dat  = 8'hC0;
    dvlo = 0;
    step();
    for (int n = 0; n < 12; n++) begin
      step();
      if (!dv[1]) dvlo++;
    end
    step();
    chk("gap_dv_low", 32'(dvlo), 32'd4);
    chk("gap_next_bit", 32'(dv[1]), 32'd1);
    chk("gap_hits", 32'(hit_cnt[1]), 32'd1);
    idle(25);

    // reset during the 4th bit, then a fresh frame
    clr();
    vld = 1'b1;
    dat = 8'hAA;
    step();
    vld = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    vld = 1'b1;
    dat = 8'h03;
    step();
    vld = 1'b0;
    repeat (8) step();
    chk("abort_fd0", 32'(fd_cnt[0]), 32'd1);
    chk("abort_hits0", 32'(hit_cnt[0]), 32'd1);
    chk("abort_last_hit", 32'(hit[0]), 32'd1);
    chk("abort_seq0", 32'(seq[0]), 32'h03);
    idle(15);

    // bit order
    clr();
    vld = 1'b1;
    dat = 8'h01;
    step();
    vld = 1'b0;
    repeat (8) step();
    chk("order_lsb", 32'(seq[2]), 32'h80);
    chk("order_msb", 32'(seq[0]), 32'h01);
    chk("order_hits2", 32'(hit_cnt[2]), 32'd0);
    idle(15);

    for (int n = 0; n < 800; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      vld = ($urandom_range(0, 3) != 0);
      dat = 8'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
